// File: rtl/ofifo_writeback.sv
// ofifo_writeback: drains col-wide psum rows from the corelet output FIFO into the
// psum SRAM at consecutive addresses. It either overwrites the stored rows or adds
// each OFIFO row lane-by-lane to the row already stored (read-modify-write), which
// is how multi-pass kernel tiling accumulates partial sums.
//
// Build option:
//   WRITEBACK_SAT_EN  when defined, accumulate lanes saturate to the signed psum
//                     range; when undefined they wrap modulo 2^psum_bw.
//                     Overwrite mode is the same in both builds.
module ofifo_writeback #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned addr_w  = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [addr_w-1:0]         base_addr,
    input  logic [addr_w-1:0]         num_rows,
    input  logic                      acc_mode,
    input  logic                      ofifo_valid,
    input  logic [col*psum_bw-1:0]    ofifo_out,
    output logic                      ofifo_rd,
    output logic                      sram_cen,
    output logic                      sram_wen,
    output logic [addr_w-1:0]         sram_addr,
    output logic [col*psum_bw-1:0]    sram_d,
    input  logic [col*psum_bw-1:0]    sram_q,
    output logic                      busy,
    output logic                      done,
    output logic [addr_w-1:0]         rows_written
);

    localparam int unsigned RowW = col * psum_bw;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StCap,
        StWr,
        StDone
    } state_e;

    state_e              state_q;
    logic [addr_w-1:0]   ptr_q;
    logic [addr_w-1:0]   num_q;
    logic                acc_q;
    logic [addr_w-1:0]   rows_q;
    logic [addr_w-1:0]   addr_q;
    logic [RowW-1:0]     d_q;

    logic                pop;
    logic                acc_rd;
    logic [RowW-1:0]     acc_row;
    logic [psum_bw:0]    lane_sum;

    // The pop and the accumulate read must happen in the WAIT cycle in which
    // ofifo_valid is seen, so these strobes are decoded from the current state.
    assign pop    = (state_q == StWait) && ofifo_valid;
    assign acc_rd = pop && acc_q;

    // Drive the OFIFO/SRAM strobes and the status outputs from the state register.
    always_comb begin
        ofifo_rd     = pop;
        sram_cen     = !(acc_rd || (state_q == StWr));
        sram_wen     = (state_q != StWr);
        sram_addr    = acc_rd ? ptr_q : addr_q;
        sram_d       = d_q;
        busy         = (state_q != StIdle);
        done         = (state_q == StDone);
        rows_written = rows_q;
    end

    // Per-lane signed add of the OFIFO row and the stored row; lanes never carry
    // into each other because each sum is formed in its own psum_bw+1 bit slot.
    always_comb begin
        acc_row  = '0;
        lane_sum = '0;
        for (int i = 0; i < int'(col); i++) begin
            lane_sum = {ofifo_out[i*psum_bw + psum_bw - 1], ofifo_out[i*psum_bw +: psum_bw]}
                     + {sram_q[i*psum_bw + psum_bw - 1], sram_q[i*psum_bw +: psum_bw]};
`ifdef WRITEBACK_SAT_EN
            // Top two bits disagree only when the signed sum left the lane range.
            if (lane_sum[psum_bw] != lane_sum[psum_bw-1]) begin
                acc_row[i*psum_bw +: psum_bw] = lane_sum[psum_bw]
                    ? {1'b1, {(psum_bw-1){1'b0}}}
                    : {1'b0, {(psum_bw-1){1'b1}}};
            end else begin
                acc_row[i*psum_bw +: psum_bw] = lane_sum[psum_bw-1:0];
            end
`else
            acc_row[i*psum_bw +: psum_bw] = lane_sum[psum_bw-1:0];
`endif
        end
    end

    // Transfer FSM: WAIT pops (and reads in accumulate mode), CAP captures the row
    // into the write-data register, WR writes it and advances the pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            num_q   <= '0;
            acc_q   <= 1'b0;
            rows_q  <= '0;
            addr_q  <= '0;
            d_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ptr_q   <= base_addr;
                        num_q   <= num_rows;
                        acc_q   <= acc_mode;
                        rows_q  <= '0;
                        state_q <= (num_rows == '0) ? StDone : StWait;
                    end
                end
                StWait: begin
                    if (ofifo_valid) begin
                        // Keep the read address visible afterwards, as held state.
                        if (acc_q) begin
                            addr_q <= ptr_q;
                        end
                        state_q <= StCap;
                    end
                end
                StCap: begin
                    // ofifo_out and sram_q are both valid this cycle; the sum is
                    // registered here so WR drives it straight from a flop.
                    d_q     <= acc_q ? acc_row : ofifo_out;
                    addr_q  <= ptr_q;
                    state_q <= StWr;
                end
                StWr: begin
                    ptr_q   <= ptr_q + addr_w'(1);
                    rows_q  <= rows_q + addr_w'(1);
                    state_q <= (rows_q + addr_w'(1) == num_q) ? StDone : StWait;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofifo_writeback.sv
// Bench for ofifo_writeback: OFIFO and SRAM behavioural models, a reference memory
// that predicts every write at stimulus time, and a monitor that checks the DUT's
// SRAM/OFIFO traffic against the predicted queue.
module tb_ofifo_writeback;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 11;
    localparam int W   = COL * BW;
    localparam int DEPTH = 1 << AW;
    localparam int LIMIT = 3000;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_rows;
    logic          acc_mode;
    logic          ofifo_valid;
    logic [W-1:0]  ofifo_out;
    logic          ofifo_rd;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [W-1:0]  sram_d;
    logic [W-1:0]  sram_q;
    logic          busy;
    logic          done;
    logic [AW-1:0] rows_written;

    int total;
    int bad;

    logic [W-1:0]  mem     [DEPTH];
    logic [W-1:0]  ref_mem [DEPTH];
    logic [W-1:0]  fifo_q[$];
    logic [W-1:0]  dir_rows[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [W-1:0]  exp_data_q[$];
    bit            cur_acc;
    bit            hold;
    int            stall_pct;
    logic          prev_rd;

    ofifo_writeback #(
        .col     (COL),
        .psum_bw (BW),
        .addr_w  (AW)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_rows     (num_rows),
        .acc_mode     (acc_mode),
        .ofifo_valid  (ofifo_valid),
        .ofifo_out    (ofifo_out),
        .ofifo_rd     (ofifo_rd),
        .sram_cen     (sram_cen),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_d       (sram_d),
        .sram_q       (sram_q),
        .busy         (busy),
        .done         (done),
        .rows_written (rows_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference lane arithmetic in plain integers.
    function automatic logic [W-1:0] lane_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < COL; i++) begin
            s = int'($signed(x[i*BW +: BW])) + int'($signed(y[i*BW +: BW]));
`ifdef WRITEBACK_SAT_EN
            if (s > (1 << (BW - 1)) - 1) s = (1 << (BW - 1)) - 1;
            if (s < -(1 << (BW - 1))) s = -(1 << (BW - 1));
`endif
            r[i*BW +: BW] = BW'(s);
        end
        return r;
    endfunction

    // SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr] <= sram_d;
            else           sram_q <= mem[sram_addr];
        end
    end

    // OFIFO model: data appears the cycle after the read pulse.
    always @(posedge clk) begin
        if (ofifo_rd && fifo_q.size() > 0) ofifo_out <= fifo_q.pop_front();
    end

    initial begin
        ofifo_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ofifo_valid = (fifo_q.size() > 0) && !hold && (int'($urandom_range(99)) >= stall_pct);
        end
    end

    // Monitor: protocol rules and scoreboard for every SRAM access.
    initial begin
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ofifo_rd) begin
                    check("rd_not_back_to_back", W'(prev_rd), W'(0));
                    check("rd_only_when_valid", W'(ofifo_valid), W'(1));
                    check("rd_acc_read", W'({sram_cen, sram_wen}), cur_acc ? W'(2'b01) : W'(2'b11));
                end
                if (!sram_cen && sram_wen) begin
                    check("read_with_pop", W'(ofifo_rd), W'(1));
                    if (exp_addr_q.size() > 0) check("read_addr", W'(sram_addr), W'(exp_addr_q[0]));
                end
                if (!sram_cen) check("busy_on_access", W'(busy), W'(1));
                if (!sram_cen && !sram_wen) begin
                    check("write_expected", W'(exp_addr_q.size() != 0), W'(1));
                    if (exp_addr_q.size() > 0) begin
                        check("write_addr", W'(sram_addr), W'(exp_addr_q.pop_front()));
                        check("write_data", sram_d, exp_data_q.pop_front());
                    end
                end
                prev_rd = ofifo_rd;
            end
        end
    end

    task automatic set_mem(input logic [AW-1:0] a, input logic [W-1:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    // Predict the whole transfer, launch it, and wait (bounded) for done.
    task automatic run_xfer(input logic [AW-1:0] base, input logic [AW-1:0] n,
                            input bit acc, input bit timed);
        logic [W-1:0]  row;
        logic [W-1:0]  e;
        logic [AW-1:0] a;
        int cyc;
        bit seen;
        for (int j = 0; j < int'(n); j++) begin
            if (dir_rows.size() > 0) row = dir_rows.pop_front();
            else row = {$urandom(), $urandom(), $urandom(), $urandom()};
            a = base + AW'(j);
            e = acc ? lane_add(row, ref_mem[a]) : row;
            ref_mem[a] = e;
            exp_addr_q.push_back(a);
            exp_data_q.push_back(e);
            fifo_q.push_back(row);
        end
        cur_acc = acc;
        @(negedge clk);
        base_addr = base;
        num_rows  = n;
        acc_mode  = acc;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        seen  = 0;
        while (!seen && cyc <= LIMIT) begin
            if (timed) begin
                check("timed_write_slot", W'({sram_cen, sram_wen}),
                      (cyc % 3 == 0 && cyc < 3 * int'(n) + 1) ? W'(2'b00) : W'(2'b11));
                check("timed_done_slot", W'(done), W'(cyc == 3 * int'(n) + 1));
            end
            if (done) seen = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            check("done_timeout", W'(0), W'(1));
        end else begin
            if (timed || n == 0) check("done_cycle", W'(cyc), n == 0 ? W'(1) : W'(3 * int'(n) + 1));
            check("rows_written", W'(rows_written), W'(n));
            check("busy_during_done", W'(busy), W'(1));
            @(negedge clk);
            check("busy_after_done", W'(busy), W'(0));
            check("scoreboard_drained", W'(exp_addr_q.size()), W'(0));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_rows = '0;
        acc_mode = 1'b0;
        ofifo_out = '0;
        sram_q = '0;
        hold = 0;
        stall_pct = 0;
        cur_acc = 0;
        for (int i = 0; i < DEPTH; i++) set_mem(AW'(i), {$urandom(), $urandom(), $urandom(), $urandom()});

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ofifo_rd", W'(ofifo_rd), W'(0));
        check("rst_cen", W'(sram_cen), W'(1));
        check("rst_wen", W'(sram_wen), W'(1));
        check("rst_addr", W'(sram_addr), W'(0));
        check("rst_d", sram_d, W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_rows", W'(rows_written), W'(0));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_cen", W'(sram_cen), W'(1));
        check("idle_rd", W'(ofifo_rd), W'(0));
        check("idle_busy", W'(busy), W'(0));

        // Overwrite with exact 3-cycle cadence.
        run_xfer(AW'(16), AW'(3), 1'b0, 1'b1);

        // Accumulate: 100 + 23 in every lane.
        set_mem(AW'(5), {COL{16'd100}});
        dir_rows.push_back({COL{16'd23}});
        run_xfer(AW'(5), AW'(1), 1'b1, 1'b0);
        check("acc_sum_123", mem[5], {COL{16'd123}});

        // No carry from lane 0 into lane 1.
        set_mem(AW'(7), {{(COL-1){16'd5}}, 16'hFFFF});
        dir_rows.push_back({{(COL-1){16'd0}}, 16'd1});
        run_xfer(AW'(7), AW'(1), 1'b1, 1'b0);
        check("acc_no_carry", mem[7], {{(COL-1){16'd5}}, 16'h0000});

        // Lane overflow: saturate or wrap depending on build.
        set_mem(AW'(9), {{(COL-2){16'd0}}, 16'hFFFF, 16'h0001});
        dir_rows.push_back({{(COL-2){16'd0}}, 16'h8000, 16'h7FFF});
        run_xfer(AW'(9), AW'(1), 1'b1, 1'b0);
`ifdef WRITEBACK_SAT_EN
        check("acc_overflow", mem[9], {{(COL-2){16'd0}}, 16'h8000, 16'h7FFF});
`else
        check("acc_overflow", mem[9], {{(COL-2){16'd0}}, 16'h7FFF, 16'h8000});
`endif

        // Empty transfer and address wrap.
        run_xfer(AW'(300), AW'(0), 1'b0, 1'b0);
        run_xfer(AW'(DEPTH - 1), AW'(2), 1'b0, 1'b0);

        // OFIFO stall mid-transfer, with a start pulse that must be dropped.
        fork
            run_xfer(AW'(100), AW'(4), 1'b1, 1'b0);
            begin
                repeat (4) @(negedge clk);
                hold = 1;
                repeat (3) @(negedge clk);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("stall_no_rd", W'(ofifo_rd), W'(0));
                    check("stall_no_sram", W'(sram_cen), W'(1));
                    check("stall_busy", W'(busy), W'(1));
                    if (i == 5) begin
                        base_addr = AW'(500);
                        num_rows  = AW'(1);
                        acc_mode  = 1'b0;
                        start     = 1'b1;
                    end else begin
                        start = 1'b0;
                    end
                end
                hold = 0;
            end
        join

        // Randomized transfers with random OFIFO back-pressure.
        for (int t = 0; t < 25; t++) begin
            stall_pct = int'($urandom_range(60));
            run_xfer(AW'($urandom_range(DEPTH - 1)), AW'($urandom_range(8)),
                     1'($urandom_range(1)), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofifo_writeback.md
Name: ofifo_writeback

Overview:
Downstream stage of the corelet output FIFO. It drains col-wide psum rows from the OFIFO and writes them into the psum SRAM at consecutive addresses. In accumulate mode it does a per-lane read-modify-write, adding each OFIFO row to the value already stored. This supports multi-pass kernel tiling. It is driven by the top-level controller through a start/busy/done handshake.

Parameters:
col, 8, number of psum lanes per row
psum_bw, 16, bits per lane (signed two's complement)
addr_w, 11, psum SRAM address width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; latches base_addr, num_rows, acc_mode; ignored while busy
base_addr  input  addr_w  first SRAM address of the transfer
num_rows  input  addr_w  number of OFIFO rows to drain
acc_mode  input  1  0 = overwrite, 1 = read-modify-write accumulate
ofifo_valid  input  1  OFIFO holds at least one full row
ofifo_out  input  col*psum_bw  OFIFO read data, valid the cycle after ofifo_rd
ofifo_rd  output  1  OFIFO read pulse
sram_cen  output  1  SRAM chip enable, active-low
sram_wen  output  1  SRAM write enable, active-low (1 = read)
sram_addr  output  addr_w  SRAM address
sram_d  output  col*psum_bw  SRAM write data
sram_q  input  col*psum_bw  SRAM read data, valid the cycle after a read access
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last write
rows_written  output  addr_w  rows completed in the current/last transfer

Behaviour:
- Reset values: ofifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0, busy=0, done=0, rows_written=0, FSM=IDLE.
- States:
  - IDLE: on start, latch the inputs; ptr=base_addr, rows_written=0. If num_rows==0, go to DONE; else go to WAIT.
  - WAIT: if ofifo_valid, assert ofifo_rd for this cycle only and go to CAP. If acc_mode, also issue an SRAM read in the same cycle (cen=0, wen=1, addr=ptr).
  - CAP: latch ofifo_out. In acc_mode also latch sram_q. No SRAM access. Go to WR.
  - WR: cen=0, wen=0, addr=ptr. sram_d = latched OFIFO row (overwrite), or the per-lane sum of OFIFO row and SRAM row (acc). Then ptr++ and rows_written++. If rows_written+1==num_rows go to DONE, else go to WAIT.
  - DONE: done=1 for one cycle, busy=0 from the next cycle. Go to IDLE.
- Throughput is 3 cycles per row when the OFIFO is never empty; WAIT stalls indefinitely while ofifo_valid=0.
- ofifo_rd is never asserted outside WAIT, and never on two consecutive cycles.
- Lane arithmetic: lane i occupies bits [i*psum_bw +: psum_bw]. Addition is signed. Default overflow wraps modulo 2^psum_bw. No carry crosses lanes.
- Address wrap: ptr increments modulo 2^addr_w; base_addr+num_rows overflow wraps to address 0 with no error.
- Outside WAIT/WR: sram_cen=1, sram_wen=1; sram_addr and sram_d hold their last values.
- A start during busy is dropped; it has no effect on the latched parameters.
- Reset asserted mid-transfer: immediate return to reset values; a row already popped from the OFIFO is lost (accepted behaviour).

Optional Feature:
- Macro WRITEBACK_SAT_EN.
- Defined: each accumulate lane saturates to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- Undefined: lanes wrap modulo 2^psum_bw.
- Overwrite mode is unaffected either way.

Test Plan:
- Reset values: hold reset=0 -> all outputs at reset values. Release reset, no start -> FSM stays IDLE, cen=1, ofifo_rd=0.
- Overwrite: base_addr=16, num_rows=3, ofifo_valid=1 constantly, rows R0..R2 -> writes at 16,17,18 on cycles 3,6,9 after start; done pulses on cycle 10; rows_written=3.
- Accumulate: SRAM[5] lanes all 100, OFIFO row lanes all 23, num_rows=1 -> read at 5 issued with ofifo_rd; write of all lanes 123 to address 5; no cross-lane carry when lane0=0xFFFF plus 1 -> lane0=0x0000, lane1 unchanged.
- OFIFO stall and busy start: ofifo_valid low for 10 cycles mid-transfer -> no ofifo_rd, no SRAM access, busy stays 1. A start pulse during busy is ignored.
- Edge cases: num_rows=0 -> done one cycle after start, no SRAM access. base_addr=2^addr_w-1, num_rows=2 -> writes at max address then 0.
- WRITEBACK_SAT_EN: lanes 32767+1 -> 32767 and -32768+(-1) -> -32768 when defined; 32767+1 -> -32768 when undefined.
